tx_frame_ctrl: RTL and testbench

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

---
 rtl/tx_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: queues register-read and ALU results and serialises them,
// least-significant byte first, to a UART transmitter using a Busy handshake.
// Ports:
//   CLK, Reset       clock, asynchronous active-low reset
//   RdData/Rd_valid  register-file read result (1 byte per request)
//   ALU_out/_valid   ALU result; arithmetic codes (ALU_FUN[3:2]==00) send BYTES bytes
//   ALU_FUN          ALU function code
//   Busy             transmitter busy
//   Clr_Err          clears Overflow and Timeout_Err
//   Tx_Data/_valid   byte and 1-cycle strobe to the transmitter
//   Q_Full           request queue full (combinational)
//   Overflow         sticky, a request was dropped
//   Timeout_Err      sticky, Busy failed to rise after a strobe
module tx_frame_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BYTES   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned BUSY_TO = 16
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         RdData,
    input  logic                     Rd_valid,
    input  logic [BYTES*WIDTH-1:0]   ALU_out,
    input  logic                     ALU_out_valid,
    input  logic [3:0]               ALU_FUN,
    input  logic                     Busy,
    input  logic                     Clr_Err,
    output logic [WIDTH-1:0]         Tx_Data,
    output logic                     Tx_Data_valid,
    output logic                     Q_Full,
    output logic                     Overflow,
    output logic                     Timeout_Err
);

    localparam int unsigned DW = BYTES * WIDTH;
    localparam int unsigned LW = 3;
    localparam int unsigned EW = DW + LW;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BUSY_TO) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_e;

    state_e             state_q;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [DW-1:0]      sh_q;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      idx_q;
    logic [TW-1:0]      tmo_q;
    logic [WIDTH-1:0]   tx_data_q;
    logic               tx_valid_q;
    logic               ovf_q;
    logic               tmo_err_q;

    logic [CW-1:0]      free_c;
    logic               push_rd_c;
    logic               push_alu_c;
    logic               drop_c;
    logic               pop_c;
    logic               tmo_fire_c;
    logic [AW-1:0]      alu_ptr_c;
    logic [LW-1:0]      alu_len_c;
    logic [EW-1:0]      rd_entry_c;
    logic [EW-1:0]      alu_entry_c;
    logic [EW-1:0]      head_c;
    logic               unused_fun_c;

    // Admission: the Rd entry has priority; the ALU entry needs a slot of its own.
    // Free space is judged on the current count, without crediting a same-cycle pop.
    always_comb begin
        free_c      = CW'(DEPTH) - cnt_q;
        push_rd_c   = Rd_valid && (free_c != '0);
        push_alu_c  = ALU_out_valid && (free_c >= (Rd_valid ? CW'(2) : CW'(1)));
        drop_c      = (Rd_valid && !push_rd_c) || (ALU_out_valid && !push_alu_c);
        pop_c       = (state_q == LOAD);
        alu_ptr_c   = wr_ptr_q + AW'(push_rd_c);
        alu_len_c   = (ALU_FUN[3:2] == 2'b00) ? LW'(BYTES) : LW'(1);
        rd_entry_c  = {DW'(RdData), LW'(1)};
        alu_entry_c = {ALU_out, alu_len_c};
        head_c      = mem_q[rd_ptr_q];
        cnt_d       = cnt_q + CW'(push_rd_c) + CW'(push_alu_c) - CW'(pop_c);
        tmo_fire_c  = (state_q == WAIT_HI) && !Busy && (tmo_q == TW'(BUSY_TO - 1));
    end

    assign unused_fun_c = ^ALU_FUN[1:0];

    // Queue storage, no reset needed: validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push_rd_c)  mem_q[wr_ptr_q]  <= rd_entry_c;
        if (push_alu_c) mem_q[alu_ptr_c] <= alu_entry_c;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_rd_c) + AW'(push_alu_c);
            rd_ptr_q <= rd_ptr_q + AW'(pop_c);
            cnt_q    <= cnt_d;
        end
    end

    // Frame serialiser: pop, emit one byte per Busy handshake.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cnt_q != '0) state_q <= LOAD;
                end
                LOAD: begin
                    sh_q    <= head_c[EW-1:LW];
                    len_q   <= head_c[LW-1:0];
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (!Busy) begin
                        tx_data_q  <= sh_q[WIDTH-1:0];
                        sh_q       <= sh_q >> WIDTH;
                        tx_valid_q <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (Busy) begin
                        state_q <= WAIT_LO;
                    end else if (tmo_fire_c) begin
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!Busy) begin
                        if ((idx_q + LW'(1)) < len_q) begin
                            idx_q   <= idx_q + LW'(1);
                            state_q <= SEND;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            if (drop_c)       ovf_q <= 1'b1;
            else if (Clr_Err) ovf_q <= 1'b0;
            if (tmo_fire_c)   tmo_err_q <= 1'b1;
            else if (Clr_Err) tmo_err_q <= 1'b0;
        end
    end

    assign Tx_Data       = tx_data_q;
    assign Tx_Data_valid = tx_valid_q;
    assign Q_Full        = (cnt_q == CW'(DEPTH));
    assign Overflow      = ovf_q;
    assign Timeout_Err   = tmo_err_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl with a simple UART Busy model and strobe log.
module tb_tx_frame_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  RdData;
    logic        Rd_valid;
    logic [15:0] ALU_out;
    logic        ALU_out_valid;
    logic [3:0]  ALU_FUN;
    logic        Busy;
    logic        Clr_Err;
    logic [7:0]  Tx_Data;
    logic        Tx_Data_valid;
    logic        Q_Full;
    logic        Overflow;
    logic        Timeout_Err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_req   = 0;
    int nlog    = 0;
    int base    = 0;
    logic [7:0] log_d [0:63];
    int         log_t [0:63];

    logic auto_en    = 1'b1;
    logic busy_force = 1'b0;
    int   busy_cnt   = 0;

    tx_frame_ctrl #(.WIDTH(8), .BYTES(2), .DEPTH(4), .BUSY_TO(16)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .RdData        (RdData),
        .Rd_valid      (Rd_valid),
        .ALU_out       (ALU_out),
        .ALU_out_valid (ALU_out_valid),
        .ALU_FUN       (ALU_FUN),
        .Busy          (Busy),
        .Clr_Err       (Clr_Err),
        .Tx_Data       (Tx_Data),
        .Tx_Data_valid (Tx_Data_valid),
        .Q_Full        (Q_Full),
        .Overflow      (Overflow),
        .Timeout_Err   (Timeout_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe log: byte and cycle stamp of every Tx_Data_valid pulse.
    always @(negedge CLK) begin
        if (Reset && Tx_Data_valid && nlog < 64) begin
            log_d[nlog] = Tx_Data;
            log_t[nlog] = cyc;
            nlog = nlog + 1;
        end
    end

    // UART model: Busy rises with the strobe and stays high for 10 cycles.
    always @(negedge CLK) begin
        if (!auto_en)                        busy_cnt = 0;
        else if (Reset && Tx_Data_valid)     busy_cnt = 10;
        else if (busy_cnt != 0)              busy_cnt = busy_cnt - 1;
    end

    assign Busy = busy_force | (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One-cycle request; t_req is the cycle in which it was sampled.
    task automatic req(input logic rd, input logic [7:0] rdd, input logic alu,
                       input logic [3:0] fun, input logic [15:0] aout, input logic clr);
        Rd_valid      = rd;
        RdData        = rdd;
        ALU_out_valid = alu;
        ALU_FUN       = fun;
        ALU_out       = aout;
        Clr_Err       = clr;
        tick(1);
        t_req         = cyc;
        Rd_valid      = 1'b0;
        ALU_out_valid = 1'b0;
        Clr_Err       = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; RdData = '0; Rd_valid = 1'b0; ALU_out = '0;
        ALU_out_valid = 1'b0; ALU_FUN = '0; Clr_Err = 1'b0;
        tick(3);
        chk("rst_tx_data",  32'(Tx_Data), 32'h0);
        chk("rst_tx_valid", 32'(Tx_Data_valid), 32'h0);
        chk("rst_q_full",   32'(Q_Full), 32'h0);
        chk("rst_overflow", 32'(Overflow), 32'h0);
        chk("rst_timeout",  32'(Timeout_Err), 32'h0);
        Reset = 1'b1;
        tick(2);

        // Single Rd byte, minimum latency.
        base = nlog;
        req(1'b1, 8'hA5, 1'b0, 4'h0, 16'h0, 1'b0);
        tick(20);
        chk("rd_count",   32'(nlog - base), 32'd1);
        chk("rd_data",    32'(log_d[base]), 32'hA5);
        chk("rd_latency", 32'(log_t[base] - t_req), 32'd3);
        chk("rd_hold",    32'(Tx_Data), 32'hA5);

        // Two-byte arithmetic result, LSB first, second byte after Busy falls.
        base = nlog;
        req(1'b0, 8'h00, 1'b1, 4'b0010, 16'h1234, 1'b0);
        tick(40);
        chk("alu2_count", 32'(nlog - base), 32'd2);
        chk("alu2_b0",    32'(log_d[base]), 32'h34);
        chk("alu2_b1",    32'(log_d[base+1]), 32'h12);
        chk("alu2_gap",   32'(log_t[base+1] - log_t[base]), 32'd12);

        // Simultaneous Rd and non-arithmetic ALU request.
        base = nlog;
        req(1'b1, 8'h11, 1'b1, 4'b0100, 16'h0055, 1'b0);
        tick(40);
        chk("dual_count", 32'(nlog - base), 32'd2);
        chk("dual_b0",    32'(log_d[base]), 32'h11);
        chk("dual_b1",    32'(log_d[base+1]), 32'h55);
        chk("dual_ovf",   32'(Overflow), 32'h0);

        // Busy stuck high: one entry held in SEND, then fill the queue and overflow.
        busy_force = 1'b1;
        base = nlog;
        req(1'b1, 8'h50, 1'b0, 4'h0, 16'h0, 1'b0);
        tick(4);
        chk("fill_q_empty", 32'(Q_Full), 32'h0);
        for (int i = 1; i <= 4; i++) req(1'b1, 8'(8'h50 + i), 1'b0, 4'h0, 16'h0, 1'b0);
        chk("fill_q_full", 32'(Q_Full), 32'h1);
        chk("fill_no_ovf", 32'(Overflow), 32'h0);
        req(1'b1, 8'h55, 1'b0, 4'h0, 16'h0, 1'b1);
        chk("ovf_set_wins", 32'(Overflow), 32'h1);
        tick(1);
        chk("ovf_sticky",   32'(Overflow), 32'h1);
        chk("fill_none_tx", 32'(nlog - base), 32'd0);
        busy_force = 1'b0;
        tick(100);
        chk("drain_count", 32'(nlog - base), 32'd5);
        for (int i = 0; i < 5; i++) chk("drain_order", 32'(log_d[base+i]), 32'(8'h50 + i));
        chk("drain_q_full", 32'(Q_Full), 32'h0);
        req(1'b0, 8'h00, 1'b0, 4'h0, 16'h0, 1'b1);
        chk("ovf_clear", 32'(Overflow), 32'h0);

        // Busy never rises: each entry times out, remaining bytes dropped.
        auto_en = 1'b0;
        base = nlog;
        req(1'b0, 8'h00, 1'b1, 4'b0000, 16'hBBAA, 1'b0);
        req(1'b1, 8'hCC, 1'b0, 4'h0, 16'h0, 1'b0);
        tick(60);
        chk("tmo_count", 32'(nlog - base), 32'd2);
        chk("tmo_b0",    32'(log_d[base]), 32'hAA);
        chk("tmo_next",  32'(log_d[base+1]), 32'hCC);
        chk("tmo_gap",   32'(log_t[base+1] - log_t[base]), 32'd19);
        chk("tmo_flag",  32'(Timeout_Err), 32'h1);
        req(1'b0, 8'h00, 1'b0, 4'h0, 16'h0, 1'b1);
        chk("tmo_clear", 32'(Timeout_Err), 32'h0);
        auto_en = 1'b1;
        tick(2);

        // Reset between byte 0 and byte 1 of an arithmetic frame.
        base = nlog;
        req(1'b0, 8'h00, 1'b1, 4'b0000, 16'h7788, 1'b0);
        tick(8);
        chk("mid_b0", 32'(log_d[base]), 32'h88);
        Reset = 1'b0;
        #1;
        chk("mid_rst_tx_data",  32'(Tx_Data), 32'h0);
        chk("mid_rst_tx_valid", 32'(Tx_Data_valid), 32'h0);
        chk("mid_rst_q_full",   32'(Q_Full), 32'h0);
        chk("mid_rst_overflow", 32'(Overflow), 32'h0);
        chk("mid_rst_timeout",  32'(Timeout_Err), 32'h0);
        tick(2);
        Reset = 1'b1;
        tick(40);
        chk("mid_no_byte1", 32'(nlog - base), 32'd1);
        chk("mid_tx_data",  32'(Tx_Data), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
